// File: rtl/eth_buffer_host_ctrl.sv
// Host-side initiator for the buffered MAC: streams host TX frames into the sender buffer
// and streams received frames out of the receiver buffer, each path with its own FSM.
module eth_buffer_host_ctrl #(
  parameter int  buf_size_p           = 2048,
  parameter int  axis_width_p         = 64,
  localparam int packet_size_width_lp = $clog2(buf_size_p) + 1,
  localparam int addr_width_lp        = $clog2(buf_size_p),
  localparam int bytes_lp             = axis_width_p / 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [axis_width_p-1:0]         s_tdata_i,
  input  logic [bytes_lp-1:0]             s_tkeep_i,
  input  logic                            s_tvalid_i,
  input  logic                            s_tlast_i,
  output logic                            s_tready_o,
  output logic [axis_width_p-1:0]         m_tdata_o,
  output logic [bytes_lp-1:0]             m_tkeep_o,
  output logic                            m_tvalid_o,
  output logic                            m_tlast_o,
  input  logic                            m_tready_i,
  input  logic                            tx_ready_i,
  output logic                            tx_packet_size_v_o,
  output logic [packet_size_width_lp-1:0] tx_packet_size_o,
  output logic                            send_o,
  output logic [addr_width_lp-1:0]        buffer_write_addr_o,
  output logic [1:0]                      buffer_write_op_size_o,
  output logic [axis_width_p-1:0]         buffer_write_data_o,
  output logic                            buffer_write_v_o,
  input  logic                            rx_ready_i,
  input  logic [15:0]                     rx_packet_size_i,
  output logic [addr_width_lp-1:0]        buffer_read_addr_o,
  output logic [1:0]                      buffer_read_op_size_o,
  output logic                            buffer_read_v_o,
  input  logic [axis_width_p-1:0]         buffer_read_data_i,
  output logic                            clear_buffer_o,
  output logic                            tx_drop_o,
  output logic                            rx_drop_o
);

  localparam int                  bsel_lp     = $clog2(bytes_lp);
  localparam int                  psw_lp      = packet_size_width_lp;
  localparam logic [1:0]          op_size_lp  = (axis_width_p == 64) ? 2'd3 : 2'd2;
  localparam logic [psw_lp-1:0]   buf_size_lc = psw_lp'(buf_size_p);

  localparam logic [2:0] TX_IDLE = 3'd0, TX_FILL = 3'd1, TX_DROP = 3'd2,
                         TX_SIZE = 3'd3, TX_SEND = 3'd4, TX_HOLD = 3'd5;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_LEN = 3'd1, RX_READ = 3'd2,
                         RX_CLEAR = 3'd3, RX_HOLD = 3'd4;

  function automatic logic [psw_lp-1:0] popcount(input logic [bytes_lp-1:0] k);
    logic [psw_lp-1:0] n;
    n = '0;
    for (int i = 0; i < bytes_lp; i++) n = n + psw_lp'(k[i]);
    return n;
  endfunction

  assign buffer_write_op_size_o = op_size_lp;
  assign buffer_read_op_size_o  = op_size_lp;

  // ---------------- TX path ----------------
  logic [2:0]        tx_state_q, tx_state_d;
  logic [psw_lp-1:0] byte_cnt_q, byte_cnt_d, tx_beat_q, tx_beat_d, new_cnt;
  logic              tx_drop_q, tx_drop_d, fill_over;

  assign tx_drop_o = tx_drop_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    byte_cnt_d = byte_cnt_q;
    tx_beat_d  = tx_beat_q;
    tx_drop_d  = 1'b0;
    new_cnt    = byte_cnt_q + popcount(s_tkeep_i);
    fill_over  = new_cnt > buf_size_lc;

    s_tready_o          = (tx_state_q == TX_FILL) || (tx_state_q == TX_DROP);
    buffer_write_v_o    = (tx_state_q == TX_FILL) && s_tvalid_i && !fill_over;
    buffer_write_addr_o = buffer_write_v_o ? addr_width_lp'(tx_beat_q << bsel_lp) : '0;
    buffer_write_data_o = buffer_write_v_o ? s_tdata_i : '0;
    tx_packet_size_v_o  = (tx_state_q == TX_SIZE);
    tx_packet_size_o    = tx_packet_size_v_o ? byte_cnt_q : '0;
    send_o              = (tx_state_q == TX_SEND);

    case (tx_state_q)
      TX_IDLE: if (tx_ready_i) begin
        tx_state_d = TX_FILL;
        byte_cnt_d = '0;
        tx_beat_d  = '0;
      end
      TX_FILL: if (s_tvalid_i) begin
        if (fill_over) begin
          // An overflowing beat that is also the last one ends the frame right here.
          tx_state_d = s_tlast_i ? TX_IDLE : TX_DROP;
          tx_drop_d  = s_tlast_i;
        end else begin
          byte_cnt_d = new_cnt;
          tx_beat_d  = tx_beat_q + psw_lp'(1);
          if (s_tlast_i) begin
            tx_state_d = (new_cnt == '0) ? TX_IDLE : TX_SIZE;
            tx_drop_d  = (new_cnt == '0);
          end
        end
      end
      TX_DROP: if (s_tvalid_i && s_tlast_i) begin
        tx_state_d = TX_IDLE;
        tx_drop_d  = 1'b1;
      end
      TX_SIZE: tx_state_d = TX_SEND;
      TX_SEND: tx_state_d = TX_HOLD;
      TX_HOLD: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_state_q <= TX_IDLE;
      byte_cnt_q <= '0;
      tx_beat_q  <= '0;
      tx_drop_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      byte_cnt_q <= byte_cnt_d;
      tx_beat_q  <= tx_beat_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  // ---------------- RX path ----------------
  logic [2:0]                rx_state_q, rx_state_d;
  logic [psw_lp-1:0]         beats_total_q, beats_total_d, beats_issued_q, beats_issued_d;
  logic [bytes_lp-1:0]       last_keep_q, last_keep_d, rd_keep_q, rd_keep_d, ones;
  logic                      rd_pend_q, rd_pend_d, rd_last_q, rd_last_d, rx_drop_q, rx_drop_d;
  logic [1:0]                fifo_cnt_q, fifo_cnt_d;
  logic                      fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [axis_width_p-1:0]   fifo_data_q [2];
  logic [bytes_lp-1:0]       fifo_keep_q [2];
  logic [1:0]                fifo_last_q;
  logic                      pop, issue, issue_last;
  logic [2:0]                occ;
  logic [15:0]               beats16;
  logic [bsel_lp-1:0]        rem;

  assign rx_drop_o = rx_drop_q;

  always_comb begin
    rx_state_d     = rx_state_q;
    beats_total_d  = beats_total_q;
    beats_issued_d = beats_issued_q;
    last_keep_d    = last_keep_q;
    rx_drop_d      = 1'b0;
    ones           = '1;

    m_tvalid_o = (fifo_cnt_q != 2'd0);
    m_tdata_o  = m_tvalid_o ? fifo_data_q[fifo_rd_q] : '0;
    m_tkeep_o  = m_tvalid_o ? fifo_keep_q[fifo_rd_q] : '0;
    m_tlast_o  = m_tvalid_o ? fifo_last_q[fifo_rd_q] : 1'b0;
    pop        = m_tvalid_o && m_tready_i;

    // Counting this cycle's pop as free space is what sustains one beat per cycle.
    occ        = {1'b0, fifo_cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
    issue      = (rx_state_q == RX_READ) && (beats_issued_q < beats_total_q) && (occ < 3'd2);
    issue_last = (beats_issued_q == beats_total_q - psw_lp'(1));

    buffer_read_v_o    = issue;
    buffer_read_addr_o = issue ? addr_width_lp'(beats_issued_q << bsel_lp) : '0;
    clear_buffer_o     = (rx_state_q == RX_CLEAR);

    rd_pend_d  = issue;
    rd_last_d  = issue && issue_last;
    rd_keep_d  = (issue && issue_last) ? last_keep_q : ones;
    fifo_cnt_d = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    fifo_wr_d  = fifo_wr_q ^ rd_pend_q;
    fifo_rd_d  = fifo_rd_q ^ pop;

    beats16 = (rx_packet_size_i + 16'(bytes_lp - 1)) >> bsel_lp;
    rem     = rx_packet_size_i[bsel_lp-1:0];

    case (rx_state_q)
      RX_IDLE: if (rx_ready_i) rx_state_d = RX_LEN;
      RX_LEN: begin
        if (rx_packet_size_i == 16'd0 || rx_packet_size_i > 16'(buf_size_p)) begin
          rx_state_d = RX_CLEAR;
          rx_drop_d  = 1'b1;
        end else begin
          rx_state_d     = RX_READ;
          beats_total_d  = psw_lp'(beats16);
          beats_issued_d = '0;
          last_keep_d    = (rem == '0) ? ones : ~(ones << rem);
        end
      end
      RX_READ: begin
        if (issue) beats_issued_d = beats_issued_q + psw_lp'(1);
        if (pop && m_tlast_o) rx_state_d = RX_CLEAR;
      end
      RX_CLEAR: rx_state_d = RX_HOLD;
      RX_HOLD:  rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_state_q     <= RX_IDLE;
      beats_total_q  <= '0;
      beats_issued_q <= '0;
      last_keep_q    <= '0;
      rd_pend_q      <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_keep_q      <= '0;
      rx_drop_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      fifo_wr_q      <= 1'b0;
      fifo_rd_q      <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      beats_total_q  <= beats_total_d;
      beats_issued_q <= beats_issued_d;
      last_keep_q    <= last_keep_d;
      rd_pend_q      <= rd_pend_d;
      rd_last_q      <= rd_last_d;
      rd_keep_q      <= rd_keep_d;
      rx_drop_q      <= rx_drop_d;
      fifo_cnt_q     <= fifo_cnt_d;
      fifo_wr_q      <= fifo_wr_d;
      fifo_rd_q      <= fifo_rd_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible once fifo_cnt_q says they were written.
  always_ff @(posedge clk_i) begin
    if (rd_pend_q) begin
      fifo_data_q[fifo_wr_q] <= buffer_read_data_i;
      fifo_keep_q[fifo_wr_q] <= rd_keep_q;
      fifo_last_q[fifo_wr_q] <= rd_last_q;
    end
  end

endmodule

// File: tb/tb_eth_buffer_host_ctrl.sv
// Directed bench for eth_buffer_host_ctrl: a vector table for a 60-byte TX frame plus
// hand-written sequences for overflow, RX streaming/stalls, size-0 drop, concurrency and reset.
module tb_eth_buffer_host_ctrl;

  logic        clk, reset_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic        tx_ready, tx_size_v, send;
  logic [11:0] tx_size;
  logic [10:0] wr_addr, rd_addr;
  logic [1:0]  wr_op, rd_op;
  logic [63:0] wr_data, rd_data;
  logic        wr_v, rx_ready, rd_v, clear_buf, tx_drop, rx_drop;
  logic [15:0] rx_size;

  int n_vec = 0;
  int n_err = 0;

  eth_buffer_host_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast),
    .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast),
    .m_tready_i(m_tready),
    .tx_ready_i(tx_ready), .tx_packet_size_v_o(tx_size_v), .tx_packet_size_o(tx_size),
    .send_o(send),
    .buffer_write_addr_o(wr_addr), .buffer_write_op_size_o(wr_op),
    .buffer_write_data_o(wr_data), .buffer_write_v_o(wr_v),
    .rx_ready_i(rx_ready), .rx_packet_size_i(rx_size),
    .buffer_read_addr_o(rd_addr), .buffer_read_op_size_o(rd_op), .buffer_read_v_o(rd_v),
    .buffer_read_data_i(rd_data),
    .clear_buffer_o(clear_buf), .tx_drop_o(tx_drop), .rx_drop_o(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rx_word(input logic [10:0] a);
    return {21'h0ACE5, a, 21'h1F00D, a};
  endfunction

  // Receiver-buffer model: data for a read appears on the following cycle.
  always @(posedge clk) rd_data <= rd_v ? rx_word(rd_addr) : 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_frame(input int bytes);
    int nb, rem;
    nb  = (bytes + 7) / 8;
    rem = bytes % 8;
    @(negedge clk); tx_ready = 1'b1; s_tvalid = 1'b0; #1;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tlast  = (b == nb - 1);
      s_tkeep  = (s_tlast && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      s_tdata  = {32'hCAFE0000, 32'(b)};
      #1;
      check("tx_wv", 64'(wr_v), 64'd1);
      check("tx_addr", 64'(wr_addr), 64'(b * 8));
      check("tx_wdata", wr_data, s_tdata);
    end
    @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0; #1;
    check("tx_size_v", 64'(tx_size_v), 64'd1);
    check("tx_size", 64'(tx_size), 64'(bytes));
    check("tx_tready_size", 64'(s_tready), 64'd0);
    @(negedge clk); tx_ready = 1'b0; #1;
    check("tx_send", 64'(send), 64'd1);
    @(negedge clk); #1;
    check("tx_send_once", 64'(send), 64'd0);
    check("tx_tready_hold", 64'(s_tready), 64'd0);
  endtask

  task automatic rx_run(input int size, input bit toggle);
    int nb, got, clr, drp, vcyc, first, lastc, clrc;
    logic [7:0]  exp_keep;
    logic [63:0] hold_d;
    bit stalled;
    nb = (size + 7) / 8;
    got = 0; clr = 0; drp = 0; vcyc = 0; first = -1; lastc = -1; clrc = -1; stalled = 0;
    hold_d = '0;
    @(negedge clk); rx_ready = 1'b1; rx_size = 16'(size); m_tready = 1'b1;
    for (int c = 0; c < nb * 2 + 20; c++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      m_tready = toggle ? c[0] : 1'b1;
      #1;
      if (stalled) begin
        check("rx_stall_valid", 64'(m_tvalid), 64'd1);
        check("rx_stall_data", m_tdata, hold_d);
        stalled = 0;
      end
      if (m_tvalid) begin
        vcyc++;
        if (first < 0) first = c;
        if (m_tready) begin
          exp_keep = (got == nb - 1 && size % 8 != 0) ? 8'((1 << (size % 8)) - 1) : 8'hFF;
          check("rx_data", m_tdata, rx_word(11'(got * 8)));
          check("rx_keep", 64'(m_tkeep), 64'(exp_keep));
          check("rx_last", 64'(m_tlast), 64'(got == nb - 1));
          got++;
          lastc = c;
        end else begin
          stalled = 1;
          hold_d  = m_tdata;
        end
      end
      if (clear_buf) begin clr++; clrc = c; end
      if (rx_drop) drp++;
    end
    check("rx_beats", 64'(got), 64'(nb));
    check("rx_clear_cnt", 64'(clr), 64'd1);
    check("rx_drop_cnt", 64'(drp), 64'(size == 0 ? 1 : 0));
    if (nb == 0) check("rx_no_valid", 64'(vcyc), 64'd0);
    else check("rx_clear_after_last", 64'(clrc), 64'(lastc + 1));
    if (!toggle && nb > 0) check("rx_b2b", 64'(lastc - first + 1), 64'(nb));
  endtask

  typedef struct {
    logic        tx_ready, tvalid, tlast;
    logic [7:0]  keep;
    logic        exp_tready, exp_wv;
    logic [10:0] exp_addr;
    logic        exp_size_v;
    logic [11:0] exp_size;
    logic        exp_send;
  } tx_vec_t;

  tx_vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt, ctl_cnt;

    // 60-byte TX frame, one row per cycle.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 12'd0, 1'b0};
    for (int i = 1; i <= 7; i++)
      vecs[i] = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 11'((i - 1) * 8), 1'b0, 12'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 11'd56, 1'b0, 12'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b1, 12'd60, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 12'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 12'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 12'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 12'd0, 1'b0};

    // Reset with every input active: all outputs must read zero.
    reset_n = 1'b0; tx_ready = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 8'hFF;
    s_tdata = 64'h1111_2222_3333_4444; rx_ready = 1'b1; rx_size = 16'd60; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_wv", 64'(wr_v), 64'd0);
    check("rst_wdata", wr_data, 64'd0);
    check("rst_size_v", 64'(tx_size_v), 64'd0);
    check("rst_size", 64'(tx_size), 64'd0);
    check("rst_send", 64'(send), 64'd0);
    check("rst_rd_v", 64'(rd_v), 64'd0);
    check("rst_clear", 64'(clear_buf), 64'd0);
    check("rst_drops", 64'({tx_drop, rx_drop}), 64'd0);
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_m_data", m_tdata, 64'd0);
    check("rst_m_keep_last", 64'({m_tkeep, m_tlast}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1; tx_ready = 1'b0; s_tvalid = 1'b0; rx_ready = 1'b0;

    // Table-driven 60-byte TX frame.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      tx_ready = vecs[i].tx_ready; s_tvalid = vecs[i].tvalid; s_tlast = vecs[i].tlast;
      s_tkeep = vecs[i].keep; s_tdata = {32'hF00D0000, 32'(i)};
      #1;
      check($sformatf("vec%0d_tready", i), 64'(s_tready), 64'(vecs[i].exp_tready));
      check($sformatf("vec%0d_wv", i), 64'(wr_v), 64'(vecs[i].exp_wv));
      check($sformatf("vec%0d_size_v", i), 64'(tx_size_v), 64'(vecs[i].exp_size_v));
      check($sformatf("vec%0d_send", i), 64'(send), 64'(vecs[i].exp_send));
      if (vecs[i].exp_wv) begin
        check($sformatf("vec%0d_addr", i), 64'(wr_addr), 64'(vecs[i].exp_addr));
        check($sformatf("vec%0d_wdata", i), wr_data, s_tdata);
        check($sformatf("vec%0d_op", i), 64'(wr_op), 64'd3);
      end
      if (vecs[i].exp_size_v) check($sformatf("vec%0d_size", i), 64'(tx_size), 64'(vecs[i].exp_size));
    end

    // TX overflow: 257 full beats into a 2048-byte buffer.
    wr_cnt = 0; ctl_cnt = 0;
    @(negedge clk); tx_ready = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; #1;
    for (int b = 0; b < 257; b++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tkeep = 8'hFF; s_tlast = (b == 256); s_tdata = 64'(b);
      #1;
      if (wr_v) wr_cnt++;
      if (tx_size_v || send) ctl_cnt++;
      if (b == 255) check("ovf_last_addr", 64'(wr_addr), 64'd2040);
      if (b == 256) begin
        check("ovf_257_no_write", 64'(wr_v), 64'd0);
        check("ovf_257_tready", 64'(s_tready), 64'd1);
      end
    end
    @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0; tx_ready = 1'b0; #1;
    check("ovf_tx_drop", 64'(tx_drop), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (tx_size_v || send || tx_drop) ctl_cnt++;
    end
    check("ovf_writes", 64'(wr_cnt), 64'd256);
    check("ovf_no_size_send", 64'(ctl_cnt), 64'd0);

    // RX streaming, stalls and size-0 drop.
    rx_run(1500, 1'b0);
    rx_run(64, 1'b1);
    rx_run(0, 1'b0);

    // TX and RX concurrently.
    fork
      tx_frame(60);
      rx_run(60, 1'b0);
    join

    // Reset in the middle of a TX frame (during beat 3), then a clean frame.
    @(negedge clk); tx_ready = 1'b1; s_tvalid = 1'b0; #1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); s_tvalid = 1'b1; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tdata = 64'(b);
    end
    @(negedge clk); reset_n = 1'b0; s_tdata = 64'd3;
    @(negedge clk); #1;
    check("mid_rst_tready", 64'(s_tready), 64'd0);
    check("mid_rst_wv", 64'(wr_v), 64'd0);
    check("mid_rst_ctl", 64'({tx_size_v, send, tx_drop}), 64'd0);
    @(negedge clk); reset_n = 1'b1; s_tvalid = 1'b0; tx_ready = 1'b0;
    ctl_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (send || tx_size_v) ctl_cnt++;
    end
    check("mid_rst_no_send", 64'(ctl_cnt), 64'd0);
    tx_frame(60);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
